// File: rtl/boat_placer.sv
// Sequential board writer for the 5x5 battleship game: accepts one placement per boat,
// validates bounds/overlap in a single CHECK cycle, then writes the boat one cell per clock.
module boat_placer #(
    parameter int NUM_BOATS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_row,
    input  logic [2:0] cmd_col,
    input  logic       cmd_vert,
    output logic [4:0] board [4:0],
    output logic [2:0] boat_idx,
    output logic       reject,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [2:0] row_q, col_q, len_q, cnt_q;
    logic       vert_q;
    logic [3:0] row4, col4, len4, end_pos, wr_r, wr_c;
    logic       in_bounds, overlap, legal, last_cell;

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is decoded from state (WAIT only), so it never depends on cmd_valid.
    assign cmd_ready = (state == S_WAIT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    assign row4      = {1'b0, row_q};
    assign col4      = {1'b0, col_q};
    assign len4      = {1'b0, len_q};
    assign end_pos   = (vert_q ? row4 : col4) + len4 - 4'd1;
    assign in_bounds = (row4 <= 4'd4) && (col4 <= 4'd4) && (end_pos <= 4'd4);
    assign legal     = in_bounds && !overlap;
    assign last_cell = (cnt_q == len_q - 3'd1);
    assign wr_r      = row4 + (vert_q ? {1'b0, cnt_q} : 4'd0);
    assign wr_c      = col4 + (vert_q ? 4'd0 : {1'b0, cnt_q});

    // Overlap is the AND of the occupied board with the latched boat's footprint.
    always_comb begin
        overlap = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (board[r][c]) begin
                    if (vert_q) begin
                        if (4'(c) == col4 && 4'(r) >= row4 && 4'(r) < row4 + len4)
                            overlap = 1'b1;
                    end else begin
                        if (4'(r) == row4 && 4'(c) >= col4 && 4'(c) < col4 + len4)
                            overlap = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_WAIT;
            S_WAIT:  if (cmd_valid) state_n = S_CHECK;
            S_CHECK: state_n = legal ? S_WRITE : S_WAIT;
            S_WRITE: if (last_cell)
                         state_n = (boat_idx + 3'd1 == 3'(NUM_BOATS)) ? S_DONE : S_WAIT;
            S_DONE:  if (start) state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            vert_q   <= 1'b0;
            boat_idx <= '0;
            reject   <= 1'b0;
            for (int r = 0; r < 5; r++) board[r] <= '0;
        end else begin
            reject <= (state == S_CHECK) && !legal;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        boat_idx <= '0;
                        for (int r = 0; r < 5; r++) board[r] <= '0;
                    end
                end
                S_WAIT: begin
                    if (cmd_valid) begin
                        row_q  <= cmd_row;
                        col_q  <= cmd_col;
                        vert_q <= cmd_vert;
                        len_q  <= boat_idx + 3'd1;
                    end
                end
                S_CHECK: cnt_q <= '0;
                S_WRITE: begin
                    for (int r = 0; r < 5; r++) begin
                        for (int c = 0; c < 5; c++) begin
                            if (4'(r) == wr_r && 4'(c) == wr_c) board[r][c] <= 1'b1;
                        end
                    end
                    cnt_q <= cnt_q + 3'd1;
                    if (last_cell) boat_idx <= boat_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boat_placer.sv
// Directed bench for boat_placer: a command table with hand-computed boards, plus
// hand-written sequences for reset-in-WRITE, start-in-WRITE and restart from DONE.
module tb_boat_placer;
    localparam int NUM_BOATS = 3;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd1, ST_CHECK = 3'd2,
                           ST_WRITE = 3'd3, ST_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst, start, cmd_valid, cmd_vert;
    logic       cmd_ready, reject, done;
    logic [2:0] cmd_row, cmd_col, boat_idx, dbg_state;
    logic [4:0] board [4:0];

    int errors = 0;
    int checks = 0;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [2:0]  row;
        logic [2:0]  col;
        logic        vert;
        logic        accept;
        logic [2:0]  exp_idx;
        logic [24:0] exp_board;   // {row4, row3, row2, row1, row0}, bit c = column c
    } vec_t;

    vec_t vecs[7];
    vec_t tv;

    always #5 clk = ~clk;

    boat_placer #(.NUM_BOATS(NUM_BOATS)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_vert(cmd_vert), .board(board), .boat_idx(boat_idx),
        .reject(reject), .done(done), .dbg_state(dbg_state)
    );

    function automatic logic [24:0] flat();
        return {board[4], board[3], board[2], board[1], board[0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input vec_t v);
        int lat;
        logic [24:0] exp_b;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        exp_q.push_back(v.exp_board);
        cmd_row   = v.row;
        cmd_col   = v.col;
        cmd_vert  = v.vert;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("in_check", 32'(dbg_state), 32'(ST_CHECK));
        check("ready_in_check", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        if (!v.accept) begin
            check("reject_pulse", 32'(reject), 32'd1);
            check("ready_after_reject", 32'(cmd_ready), 32'd1);
            @(negedge clk);
            check("reject_cleared", 32'(reject), 32'd0);
        end else begin
            check("no_reject", 32'(reject), 32'd0);
            check("in_write", 32'(dbg_state), 32'(ST_WRITE));
            lat = 0;
            while (!(cmd_ready || done) && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("write_cycles", 32'(lat), 32'(v.exp_idx));
        end
        exp_b = exp_q.pop_front();
        check("board", 32'(flat()), 32'(exp_b));
        check("boat_idx", 32'(boat_idx), 32'(v.exp_idx));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cmd_valid = 1'b0;
        cmd_row = '0; cmd_col = '0; cmd_vert = 1'b0;

        // Reset takes effect before any clock edge.
        #2;
        check("rst_board", 32'(flat()), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(boat_idx), 32'd0);
        check("rst_reject", 32'(reject), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ignores_valid", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_state", 32'(dbg_state), 32'(ST_WAIT));
        check("start_ready", 32'(cmd_ready), 32'd1);

        vecs[0] = '{3'd0, 3'd0, 1'b0, 1'b1, 3'd1, {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001}};
        vecs[1] = '{3'd3, 3'd4, 1'b0, 1'b0, 3'd1, {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001}};
        vecs[2] = '{3'd0, 3'd0, 1'b1, 1'b0, 3'd1, {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001}};
        vecs[3] = '{3'd2, 3'd1, 1'b0, 1'b1, 3'd2, {5'b00000, 5'b00000, 5'b00110, 5'b00000, 5'b00001}};
        vecs[4] = '{3'd5, 3'd0, 1'b0, 1'b0, 3'd2, {5'b00000, 5'b00000, 5'b00110, 5'b00000, 5'b00001}};
        vecs[5] = '{3'd3, 3'd4, 1'b1, 1'b0, 3'd2, {5'b00000, 5'b00000, 5'b00110, 5'b00000, 5'b00001}};
        vecs[6] = '{3'd1, 3'd4, 1'b1, 1'b1, 3'd3, {5'b00000, 5'b10000, 5'b10110, 5'b10000, 5'b00001}};
        for (int i = 0; i < 7; i++) send(vecs[i]);

        check("done_level", 32'(done), 32'd1);
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        check("done_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_row = 3'd4; cmd_col = 3'd0; cmd_vert = 1'b0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        check("done_holds_board", 32'(flat()), 32'({5'b00000, 5'b10000, 5'b10110, 5'b10000, 5'b00001}));
        check("done_holds", 32'(done), 32'd1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_board", 32'(flat()), 32'd0);
        check("restart_idx", 32'(boat_idx), 32'd0);
        check("restart_ready", 32'(cmd_ready), 32'd1);
        check("restart_done", 32'(done), 32'd0);

        tv = '{3'd0, 3'd0, 1'b0, 1'b1, 3'd1, {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001}};
        send(tv);
        tv = '{3'd0, 3'd0, 1'b1, 1'b0, 3'd1, {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001}};
        send(tv);
        tv = '{3'd3, 3'd0, 1'b1, 1'b1, 3'd2, {5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00001}};
        send(tv);

        // Boat 2 at (0,2,h): start pulsed during WRITE, reset after the second cell.
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        check("g2_ready", 32'(cmd_ready), 32'd1);
        cmd_row = 3'd0; cmd_col = 3'd2; cmd_vert = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("g2_check", 32'(dbg_state), 32'(ST_CHECK));
        @(negedge clk);
        check("g2_write", 32'(dbg_state), 32'(ST_WRITE));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_write_ignored", 32'(dbg_state), 32'(ST_WRITE));
        check("partial_1", 32'(flat()), 32'({5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b00101}));
        @(negedge clk);
        check("partial_2", 32'(flat()), 32'({5'b00001, 5'b00001, 5'b00000, 5'b00000, 5'b01101}));
        check("partial_2_idx", 32'(boat_idx), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("midrst_board", 32'(flat()), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_idx", 32'(boat_idx), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        cmd_row = 3'd4; cmd_col = 3'd4; cmd_vert = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_ack", 32'(cmd_ready), 32'd0);
            check("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("held_valid_wait", 32'(dbg_state), 32'(ST_WAIT));
        @(negedge clk);
        cmd_valid = 1'b0;
        check("held_valid_accepted", 32'(dbg_state), 32'(ST_CHECK));
        repeat (2) @(negedge clk);
        check("corner_cell", 32'(flat()), 32'({5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000}));
        check("corner_idx", 32'(boat_idx), 32'd1);
        check("corner_ready", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
